// File: rtl/timing_bank.sv
// Multi-channel up-counter bank sharing one prescaler. Each channel has
// start/halt triggers, a live terminal count, a one-shot or auto-reload mode and a sticky flag.
module timing_bank #(
   parameter int NUM_CH  = 4,
   parameter int CNT_W   = 32,
   parameter int PRESC_W = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_CH-1:0]         ro_trig_start,
   input  logic [NUM_CH-1:0]         ro_trig_halt,
   input  logic [NUM_CH-1:0]         ro_mode,
   input  logic [NUM_CH*CNT_W-1:0]   ro_termcount,
   input  logic [PRESC_W-1:0]        ro_prescale,
   input  logic [NUM_CH-1:0]         ro_int_clr,
   input  logic [NUM_CH-1:0]         ro_int_en,
   output logic [NUM_CH-1:0]         rf_status,
   output logic [NUM_CH*CNT_W-1:0]   rf_currcount,
   output logic [NUM_CH-1:0]         rf_int,
   output logic                      rf_irq
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [PRESC_W-1:0] PRESC_ONE = 1;
   localparam logic [CNT_W-1:0]   CNT_ONE   = 1;

   logic [PRESC_W-1:0] r_presc_cnt;
   logic [PRESC_W-1:0] w_presc_next;
   logic               w_any_run;
   logic               w_tick;
   logic [NUM_CH-1:0]  w_run_vec;
   logic [NUM_CH-1:0]  w_fire_vec;
   logic [NUM_CH-1:0]  r_int;
   logic [NUM_CH-1:0]  w_int_next;
   logic               r_irq;

   // Shared prescaler: the >= compare lets a lowered ro_prescale take effect without wrapping.
   always_comb begin
      w_any_run    = |w_run_vec;
      w_tick       = w_any_run && (r_presc_cnt >= ro_prescale);
      w_presc_next = r_presc_cnt;
      if (!w_any_run) begin
         w_presc_next = '0;
      end else if (w_tick) begin
         w_presc_next = '0;
      end else begin
         w_presc_next = r_presc_cnt + PRESC_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_presc_cnt <= '0;
      end else begin
         r_presc_cnt <= w_presc_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         state_t           r_state;
         state_t           w_state_next;
         logic [CNT_W-1:0] r_cnt;
         logic [CNT_W-1:0] w_cnt_next;
         logic [CNT_W-1:0] w_term;
         logic             w_fire;

         assign w_term = ro_termcount[gi*CNT_W +: CNT_W];

         // Halt beats start, and either trigger swallows a coincident tick.
         always_comb begin
            w_state_next = r_state;
            w_cnt_next   = r_cnt;
            w_fire       = 1'b0;
            if (ro_trig_halt[gi]) begin
               w_state_next = ST_IDLE;
            end else if (ro_trig_start[gi]) begin
               w_state_next = ST_RUN;
               w_cnt_next   = '0;
            end else if ((r_state == ST_RUN) && w_tick) begin
               if (r_cnt >= w_term) begin
                  w_fire = 1'b1;
                  if (ro_mode[gi]) begin
                     w_cnt_next = '0;
                  end else begin
                     w_state_next = ST_DONE;
                  end
               end else begin
                  w_cnt_next = r_cnt + CNT_ONE;
               end
            end
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
            end else begin
               r_state <= w_state_next;
               r_cnt   <= w_cnt_next;
            end
         end

         assign w_run_vec[gi]                      = (r_state == ST_RUN);
         assign w_fire_vec[gi]                     = w_fire;
         assign rf_currcount[gi*CNT_W +: CNT_W]    = r_cnt;
      end
   endgenerate

   // A terminal event on the same cycle as a clear keeps the flag set.
   assign w_int_next = w_fire_vec | (r_int & ~ro_int_clr);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_int <= '0;
         r_irq <= 1'b0;
      end else begin
         r_int <= w_int_next;
         r_irq <= |(r_int & ro_int_en);
      end
   end

   assign rf_status = w_run_vec;
   assign rf_int    = r_int;
   assign rf_irq    = r_irq;

endmodule

// File: tb/tb_timing_bank.sv
// Bench for timing_bank: cycle model of the 4-channel build plus directed
// latency checks, and a 1-channel 8-bit build checked against its closed-form count sequence.
module tb_timing_bank;

   localparam int NCH = 4;
   localparam int CW  = 32;
   localparam int PW  = 16;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [NCH-1:0]    trig_start = '0;
   logic [NCH-1:0]    trig_halt = '0;
   logic [NCH-1:0]    mode = '0;
   logic [NCH*CW-1:0] termcount = '0;
   logic [PW-1:0]     prescale = '0;
   logic [NCH-1:0]    int_clr = '0;
   logic [NCH-1:0]    int_en = '0;
   logic [NCH-1:0]    status;
   logic [NCH*CW-1:0] currcount;
   logic [NCH-1:0]    int_flags;
   logic              irq;

   logic              start8 = 1'b0;
   logic [0:0]        status8;
   logic [7:0]        count8;
   logic [0:0]        int8;
   logic              irq8;

   int checks = 0;
   int failures = 0;
   logic cmp_en = 1'b0;

   always #5 clk = ~clk;

   timing_bank #(.NUM_CH(NCH), .CNT_W(CW), .PRESC_W(PW)) dut (
      .clk(clk), .reset(reset),
      .ro_trig_start(trig_start), .ro_trig_halt(trig_halt), .ro_mode(mode),
      .ro_termcount(termcount), .ro_prescale(prescale),
      .ro_int_clr(int_clr), .ro_int_en(int_en),
      .rf_status(status), .rf_currcount(currcount), .rf_int(int_flags), .rf_irq(irq)
   );

   timing_bank #(.NUM_CH(1), .CNT_W(8), .PRESC_W(PW)) dut8 (
      .clk(clk), .reset(reset),
      .ro_trig_start(start8), .ro_trig_halt(1'b0), .ro_mode(1'b1),
      .ro_termcount(8'd255), .ro_prescale(16'd0),
      .ro_int_clr(1'b0), .ro_int_en(1'b1),
      .rf_status(status8), .rf_currcount(count8), .rf_int(int8), .rf_irq(irq8)
   );

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // Behavioural model: a channel is either running or not (idle and done
   // look the same from outside); ticks come from a shared phase counter.
   bit        m_run [NCH];
   bit [31:0] m_cnt [NCH];
   bit        m_int [NCH];
   bit        m_irq;
   int        m_phase;

   always @(posedge clk) begin
      bit any;
      bit tick;
      bit irq_n;
      if (reset) begin
         for (int i = 0; i < NCH; i++) begin
            m_run[i] = 0; m_cnt[i] = 0; m_int[i] = 0;
         end
         m_irq = 0; m_phase = 0;
      end else begin
         any = 0;
         irq_n = 0;
         for (int i = 0; i < NCH; i++) begin
            any = any | m_run[i];
            irq_n = irq_n | (m_int[i] & int_en[i]);
         end
         tick = any && (m_phase >= int'(prescale));
         m_phase = (!any || tick) ? 0 : m_phase + 1;
         for (int i = 0; i < NCH; i++) begin
            bit fire;
            fire = 0;
            if (trig_halt[i]) begin
               m_run[i] = 0;
            end else if (trig_start[i]) begin
               m_run[i] = 1; m_cnt[i] = 0;
            end else if (m_run[i] && tick) begin
               if (m_cnt[i] >= termcount[i*CW +: CW]) begin
                  fire = 1;
                  if (mode[i]) m_cnt[i] = 0;
                  else m_run[i] = 0;
               end else begin
                  m_cnt[i] = m_cnt[i] + 1;
               end
            end
            m_int[i] = fire | (m_int[i] & ~int_clr[i]);
         end
         m_irq = irq_n;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         logic [NCH-1:0]    e_status;
         logic [NCH-1:0]    e_int;
         logic [NCH*CW-1:0] e_cnt;
         for (int i = 0; i < NCH; i++) begin
            e_status[i] = m_run[i];
            e_int[i] = m_int[i];
            e_cnt[i*CW +: CW] = m_cnt[i];
         end
         chk("model_status", 128'(status), 128'(e_status));
         chk("model_count", 128'(currcount), 128'(e_cnt));
         chk("model_int", 128'(int_flags), 128'(e_int));
         chk("model_irq", 128'(irq), 128'(m_irq));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic pulse_start(input logic [NCH-1:0] m);
      trig_start = m; step(); trig_start = '0;
   endtask

   task automatic pulse_halt(input logic [NCH-1:0] m);
      trig_halt = m; step(); trig_halt = '0;
   endtask

   task automatic pulse_clr(input logic [NCH-1:0] m);
      int_clr = m; step(); int_clr = '0;
   endtask

   function automatic logic [31:0] cnt_of(input int ch);
      return currcount[ch*CW +: CW];
   endfunction

   initial begin
      steps(3);
      cmp_en = 1'b1;
      chk("reset_status", 128'(status), 128'(0));
      chk("reset_count", 128'(currcount), 128'(0));
      chk("reset_int", 128'(int_flags), 128'(0));
      chk("reset_irq", 128'(irq), 128'(0));
      reset = 1'b0;

      // One-shot, P=0, T=5: flag at k+6, irq at k+7.
      prescale = 16'd0; termcount[0*CW +: CW] = 32'd5; mode = 4'b0000; int_en = 4'b0001;
      pulse_start(4'b0001);
      chk("os_status_k", 128'(status[0]), 128'(1));
      steps(5);
      chk("os_int_k5", 128'(int_flags[0]), 128'(0));
      step();
      chk("os_int_k6", 128'(int_flags[0]), 128'(1));
      chk("os_status_k6", 128'(status[0]), 128'(0));
      chk("os_irq_k6", 128'(irq), 128'(0));
      step();
      chk("os_irq_k7", 128'(irq), 128'(1));
      chk("os_count_hold", 128'(cnt_of(0)), 128'(5));
      pulse_clr(4'b0001);
      chk("os_clr", 128'(int_flags[0]), 128'(0));
      step();

      // Auto-reload, P=3, T=5: flags at k+24 and k+48.
      prescale = 16'd3; termcount[1*CW +: CW] = 32'd5; mode = 4'b0010; int_en = 4'b1111;
      pulse_start(4'b0010);
      steps(3);
      chk("ar_count_k3", 128'(cnt_of(1)), 128'(0));
      step();
      chk("ar_count_k4", 128'(cnt_of(1)), 128'(1));
      steps(19);
      chk("ar_count_k23", 128'(cnt_of(1)), 128'(5));
      chk("ar_int_k23", 128'(int_flags[1]), 128'(0));
      step();
      chk("ar_int_k24", 128'(int_flags[1]), 128'(1));
      chk("ar_count_k24", 128'(cnt_of(1)), 128'(0));
      pulse_clr(4'b0010);
      chk("ar_clr_k25", 128'(int_flags[1]), 128'(0));
      steps(22);
      chk("ar_int_k47", 128'(int_flags[1]), 128'(0));
      step();
      chk("ar_int_k48", 128'(int_flags[1]), 128'(1));
      pulse_halt(4'b0010);
      pulse_clr(4'b0010);

      // Halt at 40, then start and restart while running.
      prescale = 16'd0; termcount[2*CW +: CW] = 32'd100;
      pulse_start(4'b0100);
      steps(40);
      chk("halt_count_pre", 128'(cnt_of(2)), 128'(40));
      pulse_halt(4'b0100);
      chk("halt_status", 128'(status[2]), 128'(0));
      chk("halt_count", 128'(cnt_of(2)), 128'(40));
      steps(5);
      chk("halt_count_later", 128'(cnt_of(2)), 128'(40));
      chk("halt_no_int", 128'(int_flags[2]), 128'(0));
      pulse_start(4'b0100);
      chk("restart_count", 128'(cnt_of(2)), 128'(0));
      steps(10);
      chk("run_count_10", 128'(cnt_of(2)), 128'(10));
      pulse_start(4'b0100);
      chk("rerun_count", 128'(cnt_of(2)), 128'(0));
      pulse_halt(4'b0100);

      // Start+halt together, and clear coinciding with a terminal event.
      trig_start = 4'b1000; trig_halt = 4'b1000;
      step();
      trig_start = '0; trig_halt = '0;
      chk("start_halt_idle", 128'(status[3]), 128'(0));
      termcount[0*CW +: CW] = 32'd2; mode = 4'b0000;
      pulse_start(4'b0001);
      steps(2);
      int_clr = 4'b0001;
      step();
      int_clr = '0;
      chk("set_beats_clr", 128'(int_flags[0]), 128'(1));
      pulse_clr(4'b0001);

      // Lowering termcount below the count fires on the next tick.
      termcount[0*CW +: CW] = 32'd100;
      pulse_start(4'b0001);
      steps(50);
      chk("lower_pre", 128'(cnt_of(0)), 128'(50));
      termcount[0*CW +: CW] = 32'd10;
      step();
      chk("lower_int", 128'(int_flags[0]), 128'(1));
      chk("lower_status", 128'(status[0]), 128'(0));
      chk("lower_count", 128'(cnt_of(0)), 128'(50));

      // Reset mid-run.
      prescale = 16'd2; mode = 4'b1110;
      termcount[1*CW +: CW] = 32'd1000; termcount[2*CW +: CW] = 32'd1000; termcount[3*CW +: CW] = 32'd1000;
      pulse_start(4'b1110);
      steps(7);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mid_reset_status", 128'(status), 128'(0));
      chk("mid_reset_count", 128'(currcount), 128'(0));
      chk("mid_reset_int", 128'(int_flags), 128'(0));
      chk("mid_reset_irq", 128'(irq), 128'(0));
      prescale = 16'd3;
      pulse_start(4'b0001);
      steps(3);
      chk("post_reset_k3", 128'(cnt_of(0)), 128'(0));
      step();
      chk("post_reset_k4", 128'(cnt_of(0)), 128'(1));
      pulse_halt(4'b1111);

      // 8-bit single-channel build, T=255 auto-reload: count at k+j is j mod 256.
      start8 = 1'b1; step(); start8 = 1'b0;
      for (int j = 1; j <= 520; j++) begin
         step();
         chk("w8_count", 128'(count8), 128'(j % 256));
         chk("w8_int", 128'(int8), 128'(j >= 256));
         chk("w8_irq", 128'(irq8), 128'(j >= 257));
      end
      chk("w8_status", 128'(status8), 128'(1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/timing_bank.md
Name: timing_bank

Overview:
- Parametrised multi-channel successor to the single-channel `timing` counter peripheral of the RISC-V microcontroller.
- Provides NUM_CH independent up-counters sharing one programmable prescaler.
- Each channel has start/halt triggers, a per-channel terminal count, one-shot or auto-reload mode, and a sticky interrupt flag.
- Sits behind the register interface: ro_* are register-driven controls, rf_* are register-readable status; rf_irq goes to the core interrupt line.

Parameters:
- NUM_CH, 4, number of timer channels (1..16).
- CNT_W, 32, counter and terminal-count width.
- PRESC_W, 16, prescaler compare width.

Ports:
- clk  in  1  single system clock.
- reset  in  1  synchronous, active-high reset.
- ro_trig_start  in  NUM_CH  per-channel start pulse (one cycle).
- ro_trig_halt  in  NUM_CH  per-channel halt pulse (one cycle).
- ro_mode  in  NUM_CH  per-channel mode: 0 = one-shot, 1 = auto-reload.
- ro_termcount  in  NUM_CH*CNT_W  per-channel terminal count; channel i at bits [i*CNT_W +: CNT_W].
- ro_prescale  in  PRESC_W  tick divider; a tick occurs every ro_prescale+1 cycles.
- ro_int_clr  in  NUM_CH  per-channel interrupt-flag clear pulse.
- ro_int_en  in  NUM_CH  per-channel interrupt enable mask for rf_irq.
- rf_status  out  NUM_CH  1 = channel in RUN.
- rf_currcount  out  NUM_CH*CNT_W  per-channel current count, same packing as ro_termcount.
- rf_int  out  NUM_CH  sticky per-channel terminal-count flags.
- rf_irq  out  1  OR-reduction of (rf_int & ro_int_en), registered.

Behaviour:
- Reset (synchronous, on clk rising edge while reset=1): all channels go to IDLE.
  - rf_status, rf_currcount, rf_int, rf_irq, and the prescaler count all become 0.
  - Reset mid-run aborts counting immediately; no interrupt is generated.
- Prescaler (presc_cnt, PRESC_W bits):
  - Cleared and held at 0 while no channel is in RUN.
  - Otherwise, each cycle: if presc_cnt >= ro_prescale, tick=1 and presc_cnt <= 0; else presc_cnt increments.
  - ro_prescale=0 gives a tick every cycle.
  - Using >= means a reduced ro_prescale takes effect without wrap.
- Per-channel FSM, states IDLE, RUN, DONE:
  - IDLE --start--> RUN, currcount <= 0.
  - RUN on tick:
    - If currcount >= termcount, terminal event: rf_int[i] <= 1. Then mode=1: currcount <= 0, stay RUN; mode=0: go to DONE, currcount holds.
    - Else currcount <= currcount+1.
  - RUN with no tick: hold.
  - RUN --halt--> IDLE, currcount holds (readable).
  - DONE --start--> RUN, count from 0.
  - DONE --halt--> IDLE.
  - Start while already RUN restarts: currcount <= 0, state stays RUN.
- Priority and simultaneous events:
  - Start and halt in the same cycle: halt wins (IDLE).
  - Terminal event and int_clr in the same cycle: set wins (flag stays 1).
  - Start/halt in the same cycle as a tick: the trigger wins and the tick is ignored for that channel.
- Terminal count:
  - ro_termcount is sampled live every tick.
  - Lowering it below currcount fires on the next tick (>= compare).
  - termcount=0 fires on every tick.
- Latency with prescale P and terminal count T, start sampled at edge k:
  - A single running channel gets its first tick at edge k+P+1.
  - rf_int rises at edge k+(T+1)*(P+1).
  - Auto-reload period is (T+1)*(P+1) cycles.
- rf_irq is registered: it rises one cycle after the enabling rf_int/ro_int_en condition.
- Channels are fully independent except for the shared prescaler phase.
  - A channel started while another is running sees its first tick at the prescaler's next wrap, not after exactly P+1 cycles.
- Width rules:
  - currcount never exceeds 2^CNT_W-1; the >= compare guarantees a terminal event before wrap.
  - All comparisons are unsigned.

Test Plan:
- Reset, then P=0, ch0 T=5, mode=0, start pulse at edge k:
  - rf_status[0]=1 from k.
  - rf_int[0]=1 at edge k+6.
  - rf_status[0]=0, rf_currcount[0]=5 thereafter.
  - rf_irq=1 at k+7 with ro_int_en[0]=1.
- P=3, ch1 T=5, mode=1, start at k:
  - rf_int[1] sets at k+24.
  - Pulse ro_int_clr[1] at k+25; flag re-sets at k+48.
  - rf_currcount[1] cycles 0..5.
- ch2 T=100 running, halt pulse when currcount=40:
  - IDLE, count holds 40, no int.
  - Start again: count restarts from 0.
- Simultaneous events:
  - start+halt on ch3 in the same cycle leaves it IDLE.
  - int_clr on the terminal-event cycle leaves rf_int=1.
- ch0 running at currcount=50, ro_termcount lowered to 10:
  - Terminal event on the next tick.
  - Then assert reset mid-run on all channels: every output is 0 the next cycle, prescaler is held.
- NUM_CH=1, CNT_W=8 build, P=0, T=255, mode=1:
  - Period of 256 cycles.
  - currcount never wraps past 255.
